// File: rtl/debug_cmd_master.sv
// Byte-stream command master for a 16-bit debug register file.
// Opcode 0x57 starts a write (addr, data_lo, data_hi); opcode 0x52 starts a read (addr).
// Each access holds its strobe until dbg_ready or a cycle limit, then answers with
// ACK / NAK (write or timeout) or the read data, low byte first.
module debug_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  dbg_a,
    output logic [15:0] dbg_di,
    input  logic [15:0] dbg_do,
    output logic        dbg_we,
    output logic        dbg_rd,
    input  logic        dbg_ready,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] RESP_ACK    = 8'h06;
    localparam logic [7:0] RESP_NAK    = 8'h15;
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DLO,
        DHI,
        ACCESS,
        RESP0,
        RESP1
    } state_t;

    state_t      state_q, state_d;
    logic        isWrite_q, isWrite_d;
    logic        nak_q, nak_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  count_q, count_d;

    // State and frame registers; reset discards any partial frame or pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            isWrite_q <= 1'b0;
            nak_q     <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 16'h0000;
            rdata_q   <= 16'h0000;
            count_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            isWrite_q <= isWrite_d;
            nak_q     <= nak_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            count_q   <= count_d;
        end
    end

    // Next-state and handshake logic; the ACCESS counter is loaded with 1 on entry
    // so that reaching TIMEOUT_VAL means the strobe has been up that many cycles.
    always_comb begin
        state_d     = state_q;
        isWrite_d   = isWrite_q;
        nak_d       = nak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        count_d     = count_q;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        dbg_we      = 1'b0;
        dbg_rd      = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_data == OP_WRITE) begin
                        isWrite_d = 1'b1;
                        state_d   = ADDR;
                    end else if (rx_data == OP_READ) begin
                        isWrite_d = 1'b0;
                        state_d   = ADDR;
                    end
                end
            end
            ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    addr_d = rx_data;
                    if (isWrite_q) begin
                        state_d = DLO;
                    end else begin
                        count_d = 8'd1;
                        state_d = ACCESS;
                    end
                end
            end
            DLO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    wdata_d[7:0] = rx_data;
                    state_d      = DHI;
                end
            end
            DHI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    wdata_d[15:8] = rx_data;
                    count_d       = 8'd1;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                dbg_we = isWrite_q;
                dbg_rd = !isWrite_q;
                if (dbg_ready) begin
                    if (!isWrite_q) begin
                        rdata_d = dbg_do;
                    end
                    nak_d   = 1'b0;
                    state_d = RESP0;
                end else if (count_q == TIMEOUT_VAL) begin
                    nak_d       = 1'b1;
                    timeout_err = 1'b1;
                    state_d     = RESP0;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            RESP0: begin
                tx_valid = 1'b1;
                if (nak_q) begin
                    tx_data = RESP_NAK;
                end else if (isWrite_q) begin
                    tx_data = RESP_ACK;
                end else begin
                    tx_data = rdata_q[7:0];
                end
                if (tx_ready) begin
                    state_d = (!isWrite_q && !nak_q) ? RESP1 : IDLE;
                end
            end
            RESP1: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[15:8];
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign dbg_a  = addr_q;
    assign dbg_di = wdata_q;

endmodule

// File: tb/tb_debug_cmd_master.sv
// Self-checking bench for debug_cmd_master: directed frames followed by random
// frames, each checked against a frame-level model of the expected strobe width,
// timeout behaviour, register hold values and response bytes.
module tb_debug_cmd_master;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic [15:0] dbg_do;
    logic        dbg_we;
    logic        dbg_rd;
    logic        dbg_ready;
    logic        busy;
    logic        timeout_err;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [15:0] modelDi     = 16'h0000;

    debug_cmd_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dbg_a      (dbg_a),
        .dbg_di     (dbg_di),
        .dbg_do     (dbg_do),
        .dbg_we     (dbg_we),
        .dbg_rd     (dbg_rd),
        .dbg_ready  (dbg_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point: counts every evaluation and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one byte on rx; the block must be ready to take it in this cycle.
    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        checkOutput("rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // A non-opcode byte must be accepted and leave the block idle.
    task automatic sendGarbage(input logic [7:0] b);
        sendByte(b);
        @(negedge clk);
        #1;
        checkOutput("garbage_idle", 32'(busy), 32'd0);
    endtask

    // Run one complete frame. readyCycle is the ACCESS cycle on which dbg_ready
    // rises (0 = never); stall is the number of RESP0 cycles with tx_ready low.
    task automatic applyStimulus(input bit isWr, input logic [7:0] addr, input logic [15:0] wdata,
                                 input int readyCycle, input logic [15:0] rdVal, input int stall);
        bit          expTimeout;
        int          expWidth;
        logic [7:0]  expResp[$];
        logic [7:0]  gotResp[$];
        logic [15:0] expDi;
        int          width;
        int          wrongStrobe;
        int          pulses;
        logic [7:0]  hold;

        expTimeout = (readyCycle < 1) || (readyCycle > TIMEOUT);
        expWidth   = expTimeout ? TIMEOUT : readyCycle;
        expDi      = isWr ? wdata : modelDi;
        if (expTimeout)   expResp.push_back(8'h15);
        else if (isWr)    expResp.push_back(8'h06);
        else begin
            expResp.push_back(rdVal[7:0]);
            expResp.push_back(rdVal[15:8]);
        end

        sendByte(isWr ? 8'h57 : 8'h52);
        sendByte(addr);
        if (isWr) begin
            sendByte(wdata[7:0]);
            sendByte(wdata[15:8]);
        end

        width       = 0;
        wrongStrobe = 0;
        pulses      = 0;
        for (int c = 1; c <= TIMEOUT + 40; c++) begin
            @(negedge clk);
            dbg_ready = (c == readyCycle);
            dbg_do    = rdVal;
            #1;
            if (!(dbg_we || dbg_rd)) break;
            width++;
            if (isWr ? dbg_rd : dbg_we) wrongStrobe++;
            if (timeout_err) pulses++;
            if (c == 1) begin
                checkOutput("dbg_a_access", 32'(dbg_a), 32'(addr));
                checkOutput("dbg_di_access", 32'(dbg_di), 32'(expDi));
            end
        end
        dbg_ready = 1'b0;
        checkOutput("strobe_width", 32'(width), 32'(expWidth));
        checkOutput("wrong_strobe", 32'(wrongStrobe), 32'd0);
        checkOutput("timeout_pulses", 32'(pulses), expTimeout ? 32'd1 : 32'd0);
        checkOutput("tx_valid_after_access", 32'(tx_valid), 32'd1);

        for (int k = 0; k < 4; k++) begin
            if (!tx_valid) break;
            if (k == 0 && stall > 0) begin
                hold     = tx_data;
                rx_valid = 1'b1;
                rx_data  = 8'h57;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    #1;
                    checkOutput("stall_tx_valid", 32'(tx_valid), 32'd1);
                    checkOutput("stall_tx_data", 32'(tx_data), 32'(hold));
                    checkOutput("stall_rx_ready", 32'(rx_ready), 32'd0);
                end
                rx_valid = 1'b0;
            end
            tx_ready = 1'b1;
            gotResp.push_back(tx_data);
            @(posedge clk);
            #1;
            tx_ready = 1'b0;
            @(negedge clk);
            #1;
        end

        checkOutput("resp_length", 32'(gotResp.size()), 32'(expResp.size()));
        for (int i = 0; i < expResp.size() && i < gotResp.size(); i++) begin
            checkOutput("resp_byte", 32'(gotResp[i]), 32'(expResp[i]));
        end
        checkOutput("idle_after_frame", 32'(busy), 32'd0);
        checkOutput("dbg_a_hold", 32'(dbg_a), 32'(addr));
        checkOutput("dbg_di_hold", 32'(dbg_di), 32'(expDi));
        modelDi = expDi;
    endtask

    // Directed scenarios followed by a batch of random frames.
    initial begin
        logic [7:0] g;

        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        dbg_do    = 16'h0000;
        dbg_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
        checkOutput("reset_dbg_a", 32'(dbg_a), 32'd0);
        checkOutput("reset_dbg_di", 32'(dbg_di), 32'd0);
        checkOutput("reset_strobes", 32'({dbg_we, dbg_rd}), 32'd0);
        checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] write 57,10,34,12 with immediate ready");
        applyStimulus(1'b1, 8'h10, 16'h1234, 1, 16'h0000, 0);

        $display("[TB] read 52,20 with ready on cycle 6");
        applyStimulus(1'b0, 8'h20, 16'h0000, 6, 16'hBEEF, 0);

        $display("[TB] read 52,30 with ready stuck low");
        applyStimulus(1'b0, 8'h30, 16'h0000, 0, 16'hA5A5, 0);

        $display("[TB] read with 10 cycles of tx backpressure");
        applyStimulus(1'b0, 8'h44, 16'h0000, 2, 16'hC3D2, 10);

        $display("[TB] garbage opcodes then read 52,11");
        sendGarbage(8'h00);
        sendGarbage(8'hFF);
        applyStimulus(1'b0, 8'h11, 16'h0000, 3, 16'h1357, 0);

        $display("[TB] reset on the third access cycle of a read");
        sendByte(8'h52);
        sendByte(8'h66);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("pre_reset_dbg_rd", 32'(dbg_rd), 32'd1);
        end
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_dbg_rd", 32'(dbg_rd), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("mid_reset_dbg_a", 32'(dbg_a), 32'd0);
        checkOutput("mid_reset_dbg_di", 32'(dbg_di), 32'd0);
        modelDi = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h77, 16'h9ABC, 2, 16'h0000, 0);

        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            int r;
            r = int'($urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == 8'h52 || g == 8'h57) g = 8'h00;
                sendGarbage(g);
            end
            applyStimulus(1'($urandom), 8'($urandom), 16'($urandom), (r > 9) ? 0 : r + 1,
                          16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/debug_cmd_master.md
DEBUG_CMD_MASTER -- requirements
Module: debug_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles a strobe is held waiting for dbg_ready (range 2..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- rx_data, input, 8: command byte.
- rx_valid, input, 1: rx_data valid.
- rx_ready, output, 1: byte accepted when rx_valid && rx_ready.
- tx_data, output, 8: response byte.
- tx_valid, output, 1: tx_data valid.
- tx_ready, input, 1: byte consumed when tx_valid && tx_ready.
- dbg_a, output, 8: debug register address.
- dbg_di, output, 16: write data to debug registers.
- dbg_do, input, 16: read data from debug registers.
- dbg_we, output, 1: write strobe.
- dbg_rd, output, 1: read strobe.
- dbg_ready, input, 1: access complete; may be combinational from the strobes.
- busy, output, 1: state != IDLE.
- timeout_err, output, 1: one-cycle pulse on timeout.

Function
REQ-004 SHALL implement the states IDLE, ADDR, DLO, DHI, ACCESS, RESP0 and RESP1.
REQ-005 Command frame:
- Write is 0x57, addr, data_lo, data_hi.
- Read is 0x52, addr.
REQ-006 SHALL assert rx_ready only in IDLE, ADDR, DLO and DHI.
REQ-007 IDLE transitions on an accepted byte:
- 0x57 sets is_write=1 and moves to ADDR.
- 0x52 sets is_write=0 and moves to ADDR.
- Any other byte is dropped and the block stays in IDLE.
REQ-008 ADDR: an accepted byte is loaded into dbg_a; next state is DLO if is_write, else ACCESS.
REQ-009 DLO loads dbg_di[7:0] then moves to DHI; DHI loads dbg_di[15:8] then moves to ACCESS.
REQ-010 ACCESS strobes:
- dbg_we = is_write and dbg_rd = !is_write, asserted combinationally during every ACCESS cycle and in no other state.
- Never both high.
REQ-011 ACCESS cycle counter:
- Cleared on entry to ACCESS.
- First ACCESS cycle counts as 1.
- Increments each ACCESS cycle in which dbg_ready=0.
REQ-012 On an ACCESS cycle with dbg_ready=1:
- For a read, capture dbg_do into rdata in that same cycle.
- Set nak=0 and move to RESP0.
- The strobe deasserts the next cycle.
REQ-013 On an ACCESS cycle with dbg_ready=0 and counter == TIMEOUT_CYCLES:
- Set nak=1, pulse timeout_err for exactly that one cycle, and move to RESP0.
- The strobe is therefore held exactly TIMEOUT_CYCLES cycles.
REQ-014 RESP0 drives tx_valid=1 with tx_data:
- 0x15 if nak.
- Otherwise 0x06 for a write.
- Otherwise rdata[7:0].
REQ-015 On acceptance in RESP0, next state is RESP1 if (read && !nak), else IDLE.
REQ-016 RESP1 drives tx_data=rdata[15:8] with tx_valid=1 and returns to IDLE on acceptance.
REQ-017 While tx_valid=1 and tx_ready=0, tx_data SHALL remain stable and no rx byte SHALL be accepted.
REQ-018 dbg_a and dbg_di SHALL hold their last loaded values outside ACCESS; a read leaves dbg_di unchanged.
REQ-019 busy SHALL equal (state != IDLE) combinationally.
REQ-020 tx_valid SHALL be 1 only in RESP0 and RESP1.
REQ-021 The block SHALL hold no inter-byte receive timeout; a partial frame waits indefinitely.
REQ-022 Throughput: an immediate dbg_ready in the first ACCESS cycle gives a strobe width of 1 cycle, with tx_valid in the next cycle.

Reset
REQ-023 rst SHALL asynchronously force:
- state=IDLE, and dbg_we=dbg_rd=0 immediately.
- dbg_a=0, dbg_di=0, rdata=0.
- is_write=0, nak=0, counter=0.
- tx_valid=0, tx_data=0, timeout_err=0, busy=0.
REQ-024 rst asserted mid-frame or mid-access SHALL discard the frame; after release, the first accepted byte is treated as an opcode.

Verification
REQ-025 Write test:
- Stimulus: rx 57,10,34,12 with dbg_ready=1 on the first ACCESS cycle.
- Response: dbg_a=0x10, dbg_di=0x1234, dbg_we high exactly 1 cycle, then tx 0x06 only.
REQ-026 Read test:
- Stimulus: rx 52,20 with dbg_ready rising on the 6th ACCESS cycle and dbg_do=0xBEEF.
- Response: dbg_rd high exactly 6 cycles, then tx 0xEF followed by 0xBE.
REQ-027 Timeout test:
- Stimulus: rx 52,30 with dbg_ready stuck at 0.
- Response: dbg_rd high exactly 255 cycles, a single timeout_err pulse, then tx 0x15 only and return to IDLE.
REQ-028 Backpressure test:
- Stimulus: read with tx_ready=0 for 10 cycles in RESP0.
- Response: tx_valid held and tx_data stable; rx_ready=0 throughout.
REQ-029 Garbage opcode test:
- Stimulus: rx 00, FF, then 52,11.
- Response: both garbage bytes accepted and dropped; the read of address 0x11 completes normally.
REQ-030 Reset test:
- Stimulus: rst asserted on the 3rd ACCESS cycle of a read.
- Response: dbg_rd=0 in the same cycle; state IDLE, tx_valid=0, dbg_a=0; after release a new write completes normally.
